// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial unsigned subtractor: one shared full-subtract cell processes a - b LSB first.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             overflow
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bf_q, bf_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] res_next;
  logic             hs1_diff, hs1_borrow, hs2_borrow, bit_diff, bit_borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  // Full subtractor built from two half-subtractor stages and the borrow flop.
  assign hs1_diff   = sa_q[0] ^ sb_q[0];
  assign hs1_borrow = ~sa_q[0] & sb_q[0];
  assign bit_diff   = hs1_diff ^ bf_q;
  assign hs2_borrow = ~hs1_diff & bf_q;
  assign bit_borrow = hs1_borrow | hs2_borrow;
  assign res_next   = {bit_diff, res_q};

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    bf_d     = bf_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          bf_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end
      S_RUN: begin
        // Abort wins even on the final bit, leaving the previous result intact.
        if (abort) begin
          bf_d    = 1'b0;
          state_d = S_IDLE;
        end else begin
          res_d = res_next[WIDTH-1:1];
          sa_d  = sa_q >> 1;
          sb_d  = sb_q >> 1;
          bf_d  = bit_borrow;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            diff_d   = res_next;
            borrow_d = bit_borrow;
            state_d  = S_DONE;
`ifdef SERIAL_SUB_OVF_EN
            ovf_d    = (a_msb_q != b_msb_q) && (bit_diff != a_msb_q);
`endif
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bf_q     <= 1'b0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      bf_q     <= bf_d;
      borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign difference = diff_q;
  assign borrow     = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign overflow   = ovf_q;
`endif

endmodule
